// File: rtl/satd4x4_pu.sv
// rtl/satd4x4_pu.sv - pipelined 4x4 SATD/SAD partition cost unit
//
// Purpose: takes one 4-pixel residual row per cycle, row-Hadamard into a
// ping-pong transpose buffer, column-Hadamard one column per cycle, sums the
// absolute coefficients per block and accumulates NUM_BLK blocks into one
// partition cost. cfg_sad bypasses both transforms (plain SAD).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   row handshake
//   cur_row, ref_row    4 packed pixels each, pixel k at [k*BIT_DEPTH +: BIT_DEPTH]
//   cfg_sad             mode, sampled with row 0 of block 0 of a partition
//   out_valid/out_ready result handshake
//   out_satd            partition cost, held while out_valid && !out_ready
module satd4x4_pu #(
  parameter int BIT_DEPTH = 8,
  parameter int NUM_BLK   = 4,
  parameter int SATD_W    = BIT_DEPTH + 8 + $clog2(NUM_BLK)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*BIT_DEPTH-1:0] cur_row,
  input  logic [4*BIT_DEPTH-1:0] ref_row,
  input  logic                   cfg_sad,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SATD_W-1:0]      out_satd
);

  localparam int RW = BIT_DEPTH + 1;
  localparam int AW = BIT_DEPTH + 3;
  localparam int CW = BIT_DEPTH + 5;
  localparam int BW = BIT_DEPTH + 8;
  localparam int NW = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;

  // Stage A state
  logic [1:0]        row_cnt_q;
  logic [NW-1:0]     blk_cnt_q;
  logic              wr_bank_q;
  logic [1:0]        bank_full_q;
  logic [1:0]        bank_sad_q;
  logic              mode_q;
  logic signed [AW-1:0] bank_q [2][4][4];  // [bank][row][col]

  // Stage B state
  logic              rd_bank_q;
  logic [1:0]        col_cnt_q;
  logic [BW-1:0]     blk_acc_q;
  logic [BW-1:0]     blk_acc_d;

  // Stage C state
  logic              fin_valid_q;
  logic              fin_sad_q;
  logic [NW-1:0]     fin_cnt_q;
  logic [SATD_W-1:0] part_acc_q;
  logic [SATD_W-1:0] part_acc_d;
  logic              out_valid_q;
  logic [SATD_W-1:0] out_satd_q;

  logic a_fire, a_sad, a_first, b_fire, c_fire, c_last;

  assign in_ready  = !bank_full_q[wr_bank_q];
  assign out_valid = out_valid_q;
  assign out_satd  = out_satd_q;

  assign a_fire  = in_valid && in_ready;
  assign a_first = (row_cnt_q == 2'd0) && (blk_cnt_q == '0);
  // The mode is taken live on the partition's first row, then held.
  assign a_sad   = a_first ? cfg_sad : mode_q;

  assign c_last = (fin_cnt_q == NW'(NUM_BLK - 1));
  // Only the last block of a partition needs the output register free.
  assign c_fire = fin_valid_q && (!c_last || !out_valid_q || out_ready);
  // blk_acc_q belongs to the pending Stage C block until Stage C consumes it.
  assign b_fire = bank_full_q[rd_bank_q] && !(fin_valid_q && !c_fire);

  // Stage A datapath: residual and row transform
  logic signed [RW-1:0] res [4];
  logic signed [AW-1:0] ra, rb, rc, rd;
  logic signed [AW-1:0] rh [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      res[k] = $signed({1'b0, cur_row[k*BIT_DEPTH +: BIT_DEPTH]})
             - $signed({1'b0, ref_row[k*BIT_DEPTH +: BIT_DEPTH]});
    end
    ra = AW'(res[0]) + AW'(res[3]);
    rb = AW'(res[1]) + AW'(res[2]);
    rc = AW'(res[1]) - AW'(res[2]);
    rd = AW'(res[0]) - AW'(res[3]);
    if (a_sad) begin
      for (int k = 0; k < 4; k++) rh[k] = AW'(res[k]);
    end else begin
      rh[0] = ra + rb;
      rh[1] = rc + rd;
      rh[2] = ra - rb;
      rh[3] = rd - rc;
    end
  end

  always_ff @(posedge clk) begin
    if (a_fire) begin
      for (int k = 0; k < 4; k++) bank_q[wr_bank_q][row_cnt_q][k] <= rh[k];
    end
  end

  // Stage B datapath: column transform and absolute sum
  logic signed [CW-1:0] cv [4];
  logic signed [CW-1:0] ch [4];
  logic signed [CW-1:0] ca, cb, cc, cd;
  logic [CW-1:0]        mag [4];
  logic [BW-1:0]        col_sum;

  always_comb begin
    for (int i = 0; i < 4; i++) cv[i] = CW'(bank_q[rd_bank_q][i][col_cnt_q]);
    ca = cv[0] + cv[3];
    cb = cv[1] + cv[2];
    cc = cv[1] - cv[2];
    cd = cv[0] - cv[3];
    if (bank_sad_q[rd_bank_q]) begin
      for (int i = 0; i < 4; i++) ch[i] = cv[i];
    end else begin
      ch[0] = ca + cb;
      ch[1] = cc + cd;
      ch[2] = ca - cb;
      ch[3] = cd - cc;
    end
    col_sum = '0;
    for (int i = 0; i < 4; i++) begin
      mag[i]  = ch[i][CW-1] ? $unsigned(-ch[i]) : $unsigned(ch[i]);
      col_sum = col_sum + BW'(mag[i]);
    end
    blk_acc_d = (col_cnt_q == 2'd0) ? col_sum : blk_acc_q + col_sum;
  end

  // Stage C datapath: SATD halves with rounding, SAD is taken as is
  logic [BW:0]       blk_rnd;
  logic [SATD_W-1:0] blk_cost;

  assign blk_rnd    = ({1'b0, blk_acc_q} + (BW + 1)'(1)) >> 1;
  assign blk_cost   = fin_sad_q ? SATD_W'(blk_acc_q) : SATD_W'(blk_rnd);
  assign part_acc_d = part_acc_q + blk_cost;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q   <= '0;
      blk_cnt_q   <= '0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= '0;
      bank_sad_q  <= '0;
      mode_q      <= 1'b0;
      rd_bank_q   <= 1'b0;
      col_cnt_q   <= '0;
      blk_acc_q   <= '0;
      fin_valid_q <= 1'b0;
      fin_sad_q   <= 1'b0;
      fin_cnt_q   <= '0;
      part_acc_q  <= '0;
      out_valid_q <= 1'b0;
      out_satd_q  <= '0;
    end else begin
      if (a_fire) begin
        row_cnt_q             <= row_cnt_q + 2'd1;
        bank_sad_q[wr_bank_q] <= a_sad;
        if (a_first) mode_q <= cfg_sad;
        if (row_cnt_q == 2'd3) begin
          bank_full_q[wr_bank_q] <= 1'b1;
          wr_bank_q              <= ~wr_bank_q;
          blk_cnt_q <= (blk_cnt_q == NW'(NUM_BLK - 1)) ? '0 : blk_cnt_q + NW'(1);
        end
      end

      if (c_fire) begin
        fin_valid_q <= 1'b0;
        if (c_last) begin
          out_satd_q <= part_acc_d;
          part_acc_q <= '0;
          fin_cnt_q  <= '0;
        end else begin
          part_acc_q <= part_acc_d;
          fin_cnt_q  <= fin_cnt_q + NW'(1);
        end
      end

      // Placed after Stage C so a block finishing here re-arms fin_valid_q.
      if (b_fire) begin
        col_cnt_q <= col_cnt_q + 2'd1;
        blk_acc_q <= blk_acc_d;
        if (col_cnt_q == 2'd3) begin
          bank_full_q[rd_bank_q] <= 1'b0;
          rd_bank_q              <= ~rd_bank_q;
          fin_valid_q            <= 1'b1;
          fin_sad_q              <= bank_sad_q[rd_bank_q];
        end
      end

      if (c_fire && c_last) out_valid_q <= 1'b1;
      else if (out_ready)   out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_satd4x4_pu.sv
// tb/tb_satd4x4_pu.sv - self-checking bench for satd4x4_pu
`timescale 1ns/1ps
module tb_satd4x4_pu;
  localparam int BD = 8;
  localparam int NB = 4;
  localparam int SW = BD + 8 + $clog2(NB);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4*BD-1:0] cur_row = '0;
  logic [4*BD-1:0] ref_row = '0;
  logic          cfg_sad = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] out_satd;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int pc [16][4][4];
  int pr [16][4][4];
  logic [SW-1:0] res_q [$];
  int res_cyc [$];

  satd4x4_pu #(.BIT_DEPTH(BD), .NUM_BLK(NB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .cur_row(cur_row), .ref_row(ref_row), .cfg_sad(cfg_sad),
    .out_valid(out_valid), .out_ready(out_ready), .out_satd(out_satd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      res_q.push_back(out_satd);
      res_cyc.push_back(cyc);
    end
  end

  function automatic int hsign(input int a, input int b);
    return ($countones(a & b) % 2) ? -1 : 1;
  endfunction

  // Reference: |H * X * H| summed over all 16 coefficients, H Sylvester order.
  function automatic int blk_model(input int b, input logic sad);
    int s, t;
    s = 0;
    for (int u = 0; u < 4; u++) begin
      for (int v = 0; v < 4; v++) begin
        if (sad) begin
          t = pc[b][u][v] - pr[b][u][v];
        end else begin
          t = 0;
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
              t += hsign(u, i) * (pc[b][i][j] - pr[b][i][j]) * hsign(j, v);
        end
        s += (t < 0) ? -t : t;
      end
    end
    return sad ? s : (s + 1) / 2;
  endfunction

  function automatic int part_model(input int p, input logic sad);
    int s;
    s = 0;
    for (int b = 0; b < NB; b++) s += blk_model(p * NB + b, sad);
    return s;
  endfunction

  task automatic fill(input int b, input int c, input int r);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        pc[b][i][j] = c;
        pr[b][i][j] = r;
      end
  endtask

  task automatic fill_rand(input int nblk);
    for (int b = 0; b < nblk; b++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          pc[b][i][j] = int'($urandom_range(0, 255));
          pr[b][i][j] = int'($urandom_range(0, 255));
        end
  endtask

  task automatic apply_reset;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_row(input int b, input int i, input logic sad);
    int w;
    for (int k = 0; k < 4; k++) begin
      cur_row[k*BD +: BD] = BD'(pc[b][i][k]);
      ref_row[k*BD +: BD] = BD'(pr[b][i][k]);
    end
    cfg_sad = sad;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (w > 0) stall_cnt++;
    if (!in_ready) begin
      n_vec++; n_fail++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Mode toggles on every row except the first to show mid-partition changes are ignored.
  task automatic send_part(input int p, input logic sad);
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < 4; i++)
        push_row(p * NB + b, i, (b == 0 && i == 0) ? sad : ~sad);
  endtask

  task automatic get_result(output logic [SW-1:0] v, output int lat, output bit ok);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = out_valid;
    v = out_satd;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_satd !== '0) begin n_fail++; $display("FAIL reset_out_satd: got %0d want 0", out_satd); end
  endtask

  task automatic test_zero;
    logic [SW-1:0] v; int lat; bit ok;
    for (int b = 0; b < NB; b++) fill(b, 'h5A, 'h5A);
    send_part(0, 1'b0);
    get_result(v, lat, ok);
    n_vec++; if (!ok || v !== SW'(0)) begin n_fail++; $display("FAIL zero_satd: got %0d valid=%0b want 0", v, ok); end
    n_vec++; if (lat !== 5) begin n_fail++; $display("FAIL zero_latency: got %0d want 5", lat); end
  endtask

  task automatic test_const;
    logic [SW-1:0] v; int lat; bit ok;
    for (int b = 0; b < NB; b++) fill(b, 10, 0);
    send_part(0, 1'b0);
    get_result(v, lat, ok);
    n_vec++; if (!ok || v !== SW'(320)) begin n_fail++; $display("FAIL const_satd: got %0d want 320", v); end
    send_part(0, 1'b1);
    get_result(v, lat, ok);
    n_vec++; if (!ok || v !== SW'(640)) begin n_fail++; $display("FAIL const_sad: got %0d want 640", v); end
  endtask

  task automatic test_single_pixel;
    logic [SW-1:0] v; int lat; bit ok;
    for (int pos = 0; pos < 16; pos++) begin
      for (int b = 0; b < NB; b++) fill(b, 0, 0);
      pc[0][pos / 4][pos % 4] = 255;
      send_part(0, 1'b0);
      get_result(v, lat, ok);
      n_vec++;
      if (!ok || v !== SW'(2040)) begin
        n_fail++; $display("FAIL single_pixel_%0d: got %0d want 2040", pos, v);
      end
    end
  endtask

  task automatic test_checker;
    logic [SW-1:0] v; int lat; bit ok;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          pc[b][i][j] = ((i + j) % 2) ? 0 : 255;
          pr[b][i][j] = ((i + j) % 2) ? 255 : 0;
        end
    send_part(0, 1'b0);
    get_result(v, lat, ok);
    n_vec++; if (!ok || v !== SW'(8160)) begin n_fail++; $display("FAIL checker: got %0d want 8160", v); end
  endtask

  task automatic test_back_to_back;
    int w;
    int exp_v [3];
    fill_rand(12);
    exp_v[0] = part_model(0, 1'b0);
    exp_v[1] = part_model(1, 1'b1);
    exp_v[2] = part_model(2, 1'b0);
    res_q.delete(); res_cyc.delete();
    stall_cnt = 0;
    out_ready = 1'b1;
    send_part(0, 1'b0);
    send_part(1, 1'b1);
    send_part(2, 1'b0);
    w = 0;
    while (res_q.size() < 3 && w < 100) begin @(posedge clk); #1; w++; end
    out_ready = 1'b0;
    n_vec++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL b2b_in_ready: stalls=%0d want 0", stall_cnt); end
    n_vec++;
    if (res_q.size() !== 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want 3", res_q.size());
    end else begin
      for (int p = 0; p < 3; p++) begin
        n_vec++;
        if (res_q[p] !== SW'(exp_v[p])) begin n_fail++; $display("FAIL b2b_value_%0d: got %0d want %0d", p, res_q[p], exp_v[p]); end
      end
      for (int p = 1; p < 3; p++) begin
        n_vec++;
        if (res_cyc[p] - res_cyc[p-1] !== 16) begin
          n_fail++; $display("FAIL b2b_spacing_%0d: got %0d want 16", p, res_cyc[p] - res_cyc[p-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int w, bad;
    bit saw_low;
    logic [SW-1:0] held;
    int exp_v [3];
    fill_rand(12);
    exp_v[0] = part_model(0, 1'b1);
    exp_v[1] = part_model(1, 1'b0);
    exp_v[2] = part_model(2, 1'b0);
    res_q.delete(); res_cyc.delete();
    out_ready = 1'b0;
    saw_low = 1'b0;
    bad = 0;
    fork
      begin
        send_part(0, 1'b1);
        send_part(1, 1'b0);
        send_part(2, 1'b0);
      end
      begin
        w = 0;
        while (!out_valid && w < 300) begin @(posedge clk); #1; w++; end
        held = out_satd;
        n_vec++; if (!out_valid || held !== SW'(exp_v[0])) begin n_fail++; $display("FAIL bp_first: got %0d want %0d", held, exp_v[0]); end
        repeat (40) begin
          @(posedge clk); #1;
          if (out_satd !== held || !out_valid) bad++;
          if (!in_ready) saw_low = 1'b1;
        end
        out_ready = 1'b1;
      end
    join
    w = 0;
    while (res_q.size() < 3 && w < 200) begin @(posedge clk); #1; w++; end
    out_ready = 1'b0;
    n_vec++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad); end
    n_vec++; if (saw_low !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_drop: saw_low=%0b want 1", saw_low); end
    n_vec++;
    if (res_q.size() !== 3) begin
      n_fail++; $display("FAIL bp_count: got %0d results want 3", res_q.size());
    end else begin
      for (int p = 0; p < 3; p++) begin
        n_vec++;
        if (res_q[p] !== SW'(exp_v[p])) begin n_fail++; $display("FAIL bp_value_%0d: got %0d want %0d", p, res_q[p], exp_v[p]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [SW-1:0] v; int lat, w; bit ok;
    int exp_v;
    fill_rand(8);
    exp_v = part_model(1, 1'b1);
    out_ready = 1'b0;
    send_part(0, 1'b0);
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    for (int b = 4; b < 6; b++)
      for (int i = 0; i < 4; i++) push_row(b, i, 1'b0);
    rst = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %0b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_satd !== '0) begin n_fail++; $display("FAIL rst_mid_out_satd: got %0d want 0", out_satd); end
    @(posedge clk); #1;
    rst = 1'b0;
    send_part(1, 1'b1);
    get_result(v, lat, ok);
    n_vec++; if (!ok || v !== SW'(exp_v)) begin n_fail++; $display("FAIL rst_mid_next: got %0d want %0d", v, exp_v); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_const();
    test_single_pixel();
    test_checker();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
